cu_mem_access: RTL and testbench

- Parametrised memory-stage access controller for the ThetaCore CU. It is the successor to the fixed 4-stage MEM sequencer.
- Accepts one load/store per request and drives a req/ack handshake to the SRAM/MMU port.
- Generates byte lanes, and sign- or zero-extends loads.
- Reports misaligned accesses, illegal sizes and SRAM timeouts instead of hanging.

---
 rtl/cu_mem_access.sv | 197 +++++++++++++++++++
 tb/tb_cu_mem_access.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_mem_access.sv
// cu_mem_access
// Memory-stage access controller for the ThetaCore CU. It takes one load or
// store at a time and runs a req/ack handshake on the SRAM/MMU port. It
// places store data on the right byte lanes and extends load data to XLEN.
// Misaligned accesses, illegal sizes and SRAM timeouts end the access with an
// error code, so the controller never hangs.
module cu_mem_access #(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              soc_clk,
    input  logic              MEM_reset,
    input  logic              MEM_stall,
    input  logic              mem_start,
    input  logic [AW-1:0]     addr,
    input  logic [2:0]        funct3,
    input  logic              read_or_write,
    input  logic [XLEN-1:0]   wdata,
    output logic              mem_busy,
    output logic              mem_done,
    output logic [1:0]        err_code,
    output logic [XLEN-1:0]   MEM_data,
    output logic              sram_req,
    output logic              sram_we,
    output logic [AW-1:0]     sram_addr,
    output logic [XLEN/8-1:0] sram_be,
    output logic [XLEN-1:0]   sram_wdata,
    input  logic              sram_ack,
    input  logic [XLEN-1:0]   sram_rdata
);
    localparam int            BEW        = XLEN / 8;
    localparam int            OFFW       = $clog2(BEW);
    localparam logic [7:0]    TMO        = 8'(TIMEOUT);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BEW - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Request captured in IDLE. The SRAM side is driven only from these
    // registers, so the requester may change its inputs during the handshake.
    logic [AW-1:0]   r_addr;
    logic [2:0]      r_funct3;
    logic            r_we;
    logic [XLEN-1:0] r_wdata;
    logic [7:0]      r_cnt;
    logic [1:0]      r_err;
    logic [XLEN-1:0] r_data;

    logic [1:0]      w_err_nxt;
    logic            w_accept;
    logic            w_illegal;
    logic            w_misalign;
    logic            w_timeout;
    logic [7:0]      w_cnt_inc;
    logic [OFFW-1:0] w_off;
    logic [BEW-1:0]  w_be;
    logic [XLEN-1:0] w_rshift;
    logic [XLEN-1:0] w_keep;
    logic            w_sbit;
    logic [XLEN-1:0] w_ld_ext;

    assign w_accept  = (r_state == S_IDLE) && mem_start && !MEM_stall;
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc >= TMO);
    assign w_off     = r_addr[OFFW-1:0];

    // Check the incoming request. Size legality takes priority over alignment.
    always_comb begin
        w_illegal = (funct3 == 3'b111)
                 || ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)))
                 || (read_or_write && funct3[2]);
        case (funct3[1:0])
            2'b01:   w_misalign = addr[0];
            2'b10:   w_misalign = |addr[1:0];
            2'b11:   w_misalign = |addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    // Byte enables and load extension for the latched request.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_be = BEW'(1)    << w_off;
            2'b01:   w_be = BEW'(3)    << w_off;
            2'b10:   w_be = BEW'(4'hF) << w_off;
            default: w_be = '1;
        endcase
        w_rshift = sram_rdata >> {w_off, 3'b000};
        case (r_funct3[1:0])
            2'b00:   begin w_keep = XLEN'(8'hFF);         w_sbit = w_rshift[7];  end
            2'b01:   begin w_keep = XLEN'(16'hFFFF);      w_sbit = w_rshift[15]; end
            2'b10:   begin w_keep = XLEN'(32'hFFFF_FFFF); w_sbit = w_rshift[31]; end
            default: begin w_keep = '1;                   w_sbit = 1'b0;         end
        endcase
        // funct3[2] marks the unsigned variants, which skip sign filling.
        w_ld_ext = (w_rshift & w_keep) | ((w_sbit && !r_funct3[2]) ? ~w_keep : '0);
    end

    // State register. Reset lands in IDLE at once, which drops sram_req.
    always_ff @(posedge soc_clk or posedge MEM_reset) begin
        if (MEM_reset) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next state and the error code that goes with it.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                w_err_nxt = 2'b00;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 2'b10;
                    end else if (w_misalign) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 2'b01;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An ack arriving on the last allowed cycle still wins over the timeout.
                if (sram_ack) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 2'b00;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 2'b11;
                end
            end
            S_DONE, S_ERR: begin
                if (!MEM_stall) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 2'b00;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_err_nxt   = 2'b00;
            end
        endcase
    end

    // Capture the request, run the wait counter and keep the last load result.
    always_ff @(posedge soc_clk or posedge MEM_reset) begin
        if (MEM_reset) begin
            r_addr   <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_data   <= '0;
        end else begin
            r_err <= w_err_nxt;
            if (w_accept) begin
                r_addr   <= addr;
                r_funct3 <= funct3;
                r_we     <= read_or_write;
                r_wdata  <= wdata;
                r_cnt    <= '0;
            end else if (r_state == S_REQ) begin
                r_cnt <= w_cnt_inc;
            end
            // Only a successful load updates MEM_data.
            if ((r_state == S_REQ) && sram_ack && !r_we)
                r_data <= w_ld_ext;
        end
    end

    // Decode the state into the status outputs and the SRAM port.
    always_comb begin
        mem_busy   = (r_state != S_IDLE);
        mem_done   = (r_state == S_DONE) || (r_state == S_ERR);
        sram_req   = (r_state == S_REQ);
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = '0;
        sram_wdata = '0;
        if (r_state == S_REQ) begin
            sram_we    = r_we;
            sram_addr  = r_addr & ALIGN_MASK;
            sram_be    = w_be;
            sram_wdata = r_wdata << {w_off, 3'b000};
        end
    end

    assign err_code = r_err;
    assign MEM_data = r_data;

endmodule

// File: tb/tb_cu_mem_access.sv
// Bench for cu_mem_access. It uses one XLEN=32 / TIMEOUT=4 instance and one
// XLEN=64 / TIMEOUT=15 instance. A transaction-level model predicts the SRAM
// fields, the error code and the load result. A free-running compare process
// checks the idle-time outputs against the model's last-load value.
module tb_cu_mem_access;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  f3 = '0;
    logic        rw = 1'b0;
    logic [63:0] wd = '0;
    logic [63:0] rd = '0;
    logic        st32 = 1'b0, st64 = 1'b0, ack32 = 1'b0, ack64 = 1'b0;

    logic        busy32, done32, req32, we32;
    logic [1:0]  err32;
    logic [31:0] data32, sa32, swd32;
    logic [3:0]  be32;
    logic        busy64, done64, req64, we64;
    logic [1:0]  err64;
    logic [63:0] data64, swd64;
    logic [31:0] sa64;
    logic [7:0]  be64;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] mdl32 = '0;
    logic [63:0] mdl64 = '0;

    logic        o_busy, o_done, o_req, o_we;
    logic [1:0]  o_err;
    logic [63:0] o_data, o_swd;
    logic [31:0] o_sa;
    logic [7:0]  o_be;

    cu_mem_access #(.XLEN(32), .AW(32), .TIMEOUT(4)) u_d32 (
        .soc_clk(clk), .MEM_reset(rst), .MEM_stall(stall), .mem_start(st32),
        .addr(addr), .funct3(f3), .read_or_write(rw), .wdata(wd[31:0]),
        .mem_busy(busy32), .mem_done(done32), .err_code(err32), .MEM_data(data32),
        .sram_req(req32), .sram_we(we32), .sram_addr(sa32), .sram_be(be32),
        .sram_wdata(swd32), .sram_ack(ack32), .sram_rdata(rd[31:0]));

    cu_mem_access #(.XLEN(64), .AW(32), .TIMEOUT(15)) u_d64 (
        .soc_clk(clk), .MEM_reset(rst), .MEM_stall(stall), .mem_start(st64),
        .addr(addr), .funct3(f3), .read_or_write(rw), .wdata(wd),
        .mem_busy(busy64), .mem_done(done64), .err_code(err64), .MEM_data(data64),
        .sram_req(req64), .sram_we(we64), .sram_addr(sa64), .sram_be(be64),
        .sram_wdata(swd64), .sram_ack(ack64), .sram_rdata(rd));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outcome of one access, from byte arithmetic on the address.
    function automatic void model(input int xl, input logic [31:0] a, input logic [2:0] fc,
                                  input bit st, input logic [63:0] wdat, input logic [63:0] rdat,
                                  output logic [1:0] err, output logic [7:0] be,
                                  output logic [31:0] sa, output logic [63:0] swd,
                                  output logic [63:0] ld);
        int nb = xl / 8;
        int off = int'(a % nb);
        int sz = 1 << fc[1:0];
        logic [63:0] xmask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        logic [63:0] v, keep;
        if (fc == 3'd7 || (xl == 32 && (fc == 3'd3 || fc == 3'd6)) || (st && fc >= 3'd4)) err = 2'd2;
        else if (a % sz != 0) err = 2'd1;
        else err = 2'd0;
        sa   = a - off;
        be   = (sz >= nb) ? 8'((1 << nb) - 1) : 8'(((1 << sz) - 1) << off);
        swd  = ((wdat & xmask) << (8 * off)) & xmask;
        v    = (rdat & xmask) >> (8 * off);
        keep = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        v    = v & keep;
        if (!fc[2] && sz < 8 && v[8 * sz - 1]) v = v | ~keep;
        ld   = v & xmask;
    endfunction

    task automatic snap(input bit w64);
        if (w64) begin
            o_busy = busy64; o_done = done64; o_req = req64; o_we = we64; o_err = err64;
            o_data = data64; o_swd = swd64; o_sa = sa64; o_be = be64;
        end else begin
            o_busy = busy32; o_done = done32; o_req = req32; o_we = we32; o_err = err32;
            o_data = {32'b0, data32}; o_swd = {32'b0, swd32}; o_sa = sa32; o_be = {4'b0, be32};
        end
    endtask

    // One complete access, from the start strobe until the DUT is back in IDLE.
    task automatic txn(input bit w64, input logic [31:0] a, input logic [2:0] fc, input bit st,
                       input logic [63:0] wdat, input logic [63:0] rdat,
                       input int ack_dly, input int nstall, input bit noisy);
        int tmo = w64 ? 15 : 4;
        logic [1:0] e_err, f_err;
        logic [7:0] e_be;
        logic [31:0] e_sa;
        logic [63:0] e_swd, e_ld, prev;
        int nreq, ndone, exp_req;
        model(w64 ? 64 : 32, a, fc, st, wdat, rdat, e_err, e_be, e_sa, e_swd, e_ld);
        exp_req = (e_err != 0) ? 0 : ((ack_dly < tmo) ? ack_dly + 1 : tmo);
        f_err   = (e_err != 0) ? e_err : ((ack_dly < tmo) ? 2'd0 : 2'd3);
        prev    = w64 ? mdl64 : mdl32;
        @(negedge clk);
        addr = a; f3 = fc; rw = st; wd = wdat; rd = rdat; stall = 1'b0;
        if (w64) st64 = 1'b1; else st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0; st64 = 1'b0;
        nreq = 0;
        snap(w64);
        while (o_req && nreq < 300) begin
            chk("sram_we", o_we, st);
            chk("sram_addr", o_sa, e_sa);
            chk("sram_be", o_be, e_be);
            chk("sram_wdata", o_swd, e_swd);
            chk("busy_req", o_busy, 1'b1);
            if (noisy) begin
                // Inputs change and stall/start toggle: the latched request must hold.
                stall = 1'($urandom_range(0, 1));
                addr = $urandom; wd = {$urandom, $urandom}; rw = ~rw; f3 = 3'($urandom);
                if (w64) st64 = 1'($urandom_range(0, 1)); else st32 = 1'($urandom_range(0, 1));
            end
            if (nreq == ack_dly) begin
                if (w64) ack64 = 1'b1; else ack32 = 1'b1;
            end
            @(negedge clk);
            ack32 = 1'b0; ack64 = 1'b0;
            nreq++;
            snap(w64);
        end
        chk("req_cycles", nreq, exp_req);
        st32 = 1'b0; st64 = 1'b0;
        ndone = 0;
        while (o_done && ndone < 300) begin
            chk("err_code", o_err, f_err);
            chk("req_in_done", o_req, 1'b0);
            chk("MEM_data_done", o_data, (f_err == 0 && !st) ? e_ld : prev);
            if (ndone == 0 && f_err == 0 && !st) begin
                if (w64) mdl64 = e_ld; else mdl32 = e_ld;
            end
            // A late ack arriving after a timeout must be ignored.
            if (f_err == 2'd3 && ndone == 0) begin
                if (w64) ack64 = 1'b1; else ack32 = 1'b1;
            end
            ndone++;
            stall = (ndone <= nstall);
            @(negedge clk);
            ack32 = 1'b0; ack64 = 1'b0;
            snap(w64);
        end
        chk("done_cycles", ndone, nstall + 1);
        chk("busy_after", o_busy, 1'b0);
        stall = 1'b0;
    endtask

    // Outside a completion, err_code is 0, MEM_data holds the last good load, and IDLE means no request.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (!done32) begin
                chk("idle_data32", {32'b0, data32}, mdl32);
                chk("idle_err32", err32, 2'd0);
            end
            if (!busy32) chk("idle_req32", req32, 1'b0);
            if (!done64) begin
                chk("idle_data64", data64, mdl64);
                chk("idle_err64", err64, 2'd0);
            end
            if (!busy64) chk("idle_req64", req64, 1'b0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m_err;
        logic [7:0]  m_be;
        logic [31:0] m_sa;
        logic [63:0] m_swd, m_ld;
        logic [31:0] ra;
        logic [2:0]  rf;
        bit          w;

        // Hand-computed values that pin the model.
        model(32, 32'h103, 3'b000, 1'b0, 64'h0, 64'h80FF_0000, m_err, m_be, m_sa, m_swd, m_ld);
        chk("mdl_lb_data", m_ld, 64'hFFFF_FF80);
        chk("mdl_lb_be", m_be, 8'h8);
        chk("mdl_lb_addr", m_sa, 32'h100);
        model(32, 32'h103, 3'b100, 1'b0, 64'h0, 64'h80FF_0000, m_err, m_be, m_sa, m_swd, m_ld);
        chk("mdl_lbu_data", m_ld, 64'h80);
        model(32, 32'h102, 3'b001, 1'b1, 64'h1234_ABCD, 64'h0, m_err, m_be, m_sa, m_swd, m_ld);
        chk("mdl_sh_be", m_be, 8'hC);
        chk("mdl_sh_wdata", m_swd, 64'hABCD_0000);
        model(64, 32'h8, 3'b011, 1'b0, 64'h0, 64'h0, m_err, m_be, m_sa, m_swd, m_ld);
        chk("mdl_ld_be", m_be, 8'hFF);
        model(32, 32'h101, 3'b010, 1'b0, 64'h0, 64'h0, m_err, m_be, m_sa, m_swd, m_ld);
        chk("mdl_misalign", m_err, 2'd1);
        model(32, 32'h100, 3'b011, 1'b0, 64'h0, 64'h0, m_err, m_be, m_sa, m_swd, m_ld);
        chk("mdl_illegal", m_err, 2'd2);

        // Reset state.
        #1;
        chk("rst_busy32", busy32, 1'b0);
        chk("rst_done32", done32, 1'b0);
        chk("rst_err32", err32, 2'd0);
        chk("rst_data32", data32, 32'h0);
        chk("rst_req32", req32, 1'b0);
        chk("rst_busy64", busy64, 1'b0);
        chk("rst_data64", data64, 64'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed accesses.
        txn(0, 32'h100, 3'b010, 0, 64'h0, 64'hDEAD_BEEF, 2, 0, 0);
        chk("lw_result", data32, 32'hDEAD_BEEF);
        txn(0, 32'h103, 3'b000, 0, 64'h0, 64'h80FF_0000, 0, 0, 0);
        chk("lb_result", data32, 32'hFFFF_FF80);
        txn(0, 32'h103, 3'b100, 0, 64'h0, 64'h80FF_0000, 1, 0, 0);
        chk("lbu_result", data32, 32'h0000_0080);
        txn(0, 32'h102, 3'b001, 1, 64'h1234_ABCD, 64'h0, 1, 0, 0);
        chk("sh_keeps_data", data32, 32'h0000_0080);
        txn(0, 32'h101, 3'b010, 0, 64'h0, 64'h0, 0, 0, 0);
        txn(0, 32'h100, 3'b011, 0, 64'h0, 64'h0, 0, 0, 0);
        txn(1, 32'h8, 3'b011, 0, 64'h0, 64'h8877_6655_4433_2211, 0, 0, 0);
        chk("ld_result", data64, 64'h8877_6655_4433_2211);
        txn(0, 32'h200, 3'b010, 0, 64'h0, 64'h1111_2222, 99, 0, 0);
        txn(0, 32'h204, 3'b010, 0, 64'h0, 64'hCAFE_F00D, 1, 3, 0);
        txn(1, 32'h40, 3'b010, 0, 64'h0, 64'h0, 99, 1, 0);

        // A start that arrives while stall is high is dropped.
        @(negedge clk);
        addr = 32'h300; f3 = 3'b010; rw = 1'b0; st32 = 1'b1; stall = 1'b1;
        @(negedge clk);
        st32 = 1'b0; stall = 1'b0;
        chk("stall_drop_busy", busy32, 1'b0);
        @(negedge clk);
        chk("stall_drop_busy2", busy32, 1'b0);

        // Randomized accesses on both widths.
        for (int i = 0; i < 120; i++) begin
            w  = (i % 3 == 2);
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rf[1:0]) - 32'd1);
            txn(w, ra, rf, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                w ? $urandom_range(0, 16) : $urandom_range(0, 5), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of REQ.
        txn(0, 32'h100, 3'b010, 0, 64'h0, 64'h5A5A_A5A5, 0, 0, 0);
        @(negedge clk);
        addr = 32'h200; f3 = 3'b010; rw = 1'b0; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        chk("pre_rst_req", req32, 1'b1);
        chk("pre_rst_data", data32, 32'h5A5A_A5A5);
        #2;
        rst = 1'b1;
        mdl32 = '0;
        mdl64 = '0;
        #1;
        chk("async_rst_req", req32, 1'b0);
        chk("async_rst_busy", busy32, 1'b0);
        chk("async_rst_data", data32, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy32, 1'b0);
        txn(0, 32'h104, 3'b001, 0, 64'h0, 64'h0000_8001, 0, 0, 0);
        chk("post_rst_lh", data32, 32'hFFFF_8001);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
